// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with load-use hazard detection and stall counter.
// Latency: 1 cycle D->E; lwstall is combinational from E registers and D inputs.
// Backpressure: lwstall holds fetch/decode upstream and inserts a bubble into E.
module id_ex_stage #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             regwrite_d,
    input  logic             memtoreg_d,
    input  logic             memwrite_d,
    input  logic             alusrc_d,
    input  logic             regdst_d,
    input  logic [1:0]       aluop_d,
    input  logic [WIDTH-1:0] rd1_d,
    input  logic [WIDTH-1:0] rd2_d,
    input  logic [WIDTH-1:0] signimm_d,
    input  logic [4:0]       rs_d,
    input  logic [4:0]       rt_d,
    input  logic [4:0]       rd_d,
    input  logic             flush_e,
    input  logic             clr_count,
    output logic             regwrite_e,
    output logic             memtoreg_e,
    output logic             memwrite_e,
    output logic             alusrc_e,
    output logic             regdst_e,
    output logic [1:0]       aluop_e,
    output logic [WIDTH-1:0] rd1_e,
    output logic [WIDTH-1:0] rd2_e,
    output logic [WIDTH-1:0] signimm_e,
    output logic [4:0]       rs_e,
    output logic [4:0]       rt_e,
    output logic [4:0]       rd_e,
    output logic             valid_e,
    output logic             lwstall,
    output logic [CNTW-1:0]  stall_count
);

    logic bubble;

    // Conservative: rs and rt are compared regardless of what the D instruction actually reads.
    assign lwstall = valid_e & memtoreg_e & regwrite_e & (rt_e != 5'd0) &
                     ((rt_e == rs_d) | (rt_e == rt_d));
    assign bubble  = lwstall | flush_e;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regwrite_e <= 1'b0;
            memtoreg_e <= 1'b0;
            memwrite_e <= 1'b0;
            alusrc_e   <= 1'b0;
            regdst_e   <= 1'b0;
            aluop_e    <= 2'd0;
            rd1_e      <= '0;
            rd2_e      <= '0;
            signimm_e  <= '0;
            rs_e       <= 5'd0;
            rt_e       <= 5'd0;
            rd_e       <= 5'd0;
            valid_e    <= 1'b0;
        end else if (bubble) begin
            regwrite_e <= 1'b0;
            memtoreg_e <= 1'b0;
            memwrite_e <= 1'b0;
            alusrc_e   <= 1'b0;
            regdst_e   <= 1'b0;
            aluop_e    <= 2'd0;
            rd1_e      <= '0;
            rd2_e      <= '0;
            signimm_e  <= '0;
            rs_e       <= 5'd0;
            rt_e       <= 5'd0;
            rd_e       <= 5'd0;
            valid_e    <= 1'b0;
        end else begin
            regwrite_e <= regwrite_d;
            memtoreg_e <= memtoreg_d;
            memwrite_e <= memwrite_d;
            alusrc_e   <= alusrc_d;
            regdst_e   <= regdst_d;
            aluop_e    <= aluop_d;
            rd1_e      <= rd1_d;
            rd2_e      <= rd2_d;
            signimm_e  <= signimm_d;
            rs_e       <= rs_d;
            rt_e       <= rt_d;
            rd_e       <= rd_d;
            valid_e    <= 1'b1;
        end
    end

    // Clear wins over increment; the counter sticks at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (clr_count) begin
            stall_count <= '0;
        end else if (lwstall && (stall_count != {CNTW{1'b1}})) begin
            stall_count <= stall_count + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: instruction-level model checked every cycle plus directed literal checks.
module tb_id_ex_stage;

    localparam int WIDTH = 32;
    localparam int CNTW  = 4;

    logic clk = 1'b0;
    logic reset_n;
    logic regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d;
    logic [1:0] aluop_d;
    logic [WIDTH-1:0] rd1_d, rd2_d, signimm_d;
    logic [4:0] rs_d, rt_d, rd_d;
    logic flush_e, clr_count;
    logic regwrite_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e;
    logic [1:0] aluop_e;
    logic [WIDTH-1:0] rd1_e, rd2_e, signimm_e;
    logic [4:0] rs_e, rt_e, rd_e;
    logic valid_e, lwstall;
    logic [CNTW-1:0] stall_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk(clk), .reset_n(reset_n),
        .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d), .memwrite_d(memwrite_d),
        .alusrc_d(alusrc_d), .regdst_d(regdst_d), .aluop_d(aluop_d),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .signimm_d(signimm_d),
        .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
        .flush_e(flush_e), .clr_count(clr_count),
        .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e), .memwrite_e(memwrite_e),
        .alusrc_e(alusrc_e), .regdst_e(regdst_e), .aluop_e(aluop_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .signimm_e(signimm_e),
        .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e),
        .valid_e(valid_e), .lwstall(lwstall), .stall_count(stall_count)
    );

    // Model: the instruction occupying E, and the stall tally.
    typedef struct packed {
        logic rw, mtr, mw, as, rdst;
        logic [1:0] aop;
        logic [WIDTH-1:0] r1, r2, imm;
        logic [4:0] rs, rt, rd;
        logic v;
    } ins_t;

    ins_t m_e;
    int   m_cnt;

    function automatic bit m_hazard();
        // A load in E whose destination a following instruction may read.
        return m_e.v && m_e.mtr && m_e.rw && (m_e.rt != 0) &&
               ((m_e.rt == rs_d) || (m_e.rt == rt_d));
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_e   = '0;
            m_cnt = 0;
        end else begin
            automatic bit hz = m_hazard();
            if (hz || flush_e) m_e = '0;
            else m_e = '{regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d, aluop_d,
                         rd1_d, rd2_d, signimm_d, rs_d, rt_d, rd_d, 1'b1};
            if (clr_count) m_cnt = 0;
            else if (hz && m_cnt < (1 << CNTW) - 1) m_cnt = m_cnt + 1;
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        cmp("m.regwrite_e", 32'(regwrite_e), 32'(m_e.rw));
        cmp("m.memtoreg_e", 32'(memtoreg_e), 32'(m_e.mtr));
        cmp("m.memwrite_e", 32'(memwrite_e), 32'(m_e.mw));
        cmp("m.alusrc_e",   32'(alusrc_e),   32'(m_e.as));
        cmp("m.regdst_e",   32'(regdst_e),   32'(m_e.rdst));
        cmp("m.aluop_e",    32'(aluop_e),    32'(m_e.aop));
        cmp("m.rd1_e",      rd1_e,           m_e.r1);
        cmp("m.rd2_e",      rd2_e,           m_e.r2);
        cmp("m.signimm_e",  signimm_e,       m_e.imm);
        cmp("m.rs_e",       32'(rs_e),       32'(m_e.rs));
        cmp("m.rt_e",       32'(rt_e),       32'(m_e.rt));
        cmp("m.rd_e",       32'(rd_e),       32'(m_e.rd));
        cmp("m.valid_e",    32'(valid_e),    32'(m_e.v));
        cmp("m.lwstall",    32'(lwstall),    32'(m_hazard()));
        cmp("m.stall_count", 32'(stall_count), 32'(m_cnt));
    end

    task automatic set_instr(input logic rw, input logic mtr, input logic mw, input logic as,
                             input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        regwrite_d = rw; memtoreg_d = mtr; memwrite_d = mw; alusrc_d = as;
        regdst_d = ~as; aluop_d = mtr ? 2'd0 : 2'd2;
        rs_d = rs; rt_d = rt; rd_d = rd;
        rd1_d = 32'h1000_0000 | 32'(rs); rd2_d = 32'h2000_0000 | 32'(rt);
        signimm_d = 32'h0000_0040 + 32'(rd);
    endtask

    task automatic set_lw(input logic [4:0] rt);
        set_instr(1'b1, 1'b1, 1'b0, 1'b1, 5'd29, rt, 5'd0);
    endtask

    task automatic set_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        set_instr(1'b1, 1'b0, 1'b0, 1'b0, rs, rt, rd);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    initial begin
        // Reset with busy D inputs.
        reset_n = 1'b0; flush_e = 1'b0; clr_count = 1'b0;
        set_instr(1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 5'd4, 5'd5);
        rd1_d = 32'hdead_beef;
        #1;
        cmp("rst.noedge.valid_e", 32'(valid_e), 32'd0);
        cmp("rst.noedge.rd1_e", rd1_e, 32'd0);
        cmp("rst.noedge.stall_count", 32'(stall_count), 32'd0);
        repeat (2) step();
        cmp("rst.edges.memwrite_e", 32'(memwrite_e), 32'd0);
        cmp("rst.edges.lwstall", 32'(lwstall), 32'd0);
        at_neg();
        reset_n = 1'b1;
        rd1_d = 32'h1234_5678;
        step();
        cmp("rel.rd1_e", rd1_e, 32'h1234_5678);
        cmp("rel.valid_e", 32'(valid_e), 32'd1);

        // Load-use: lw $t0 then add using $t0.
        set_lw(5'd8);
        step();
        set_add(5'd8, 5'd9, 5'd10);
        at_neg();
        cmp("lu.lwstall", 32'(lwstall), 32'd1);
        cmp("lu.count_before", 32'(stall_count), 32'd0);
        step();
        cmp("lu.bubble.valid_e", 32'(valid_e), 32'd0);
        cmp("lu.bubble.regwrite_e", 32'(regwrite_e), 32'd0);
        cmp("lu.bubble.lwstall", 32'(lwstall), 32'd0);
        cmp("lu.count_after", 32'(stall_count), 32'd1);
        step();
        cmp("lu.add.valid_e", 32'(valid_e), 32'd1);
        cmp("lu.add.rs_e", 32'(rs_e), 32'd8);

        // No false stall: destination $zero, then unrelated registers.
        set_instr(1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
        step();
        set_add(5'd0, 5'd0, 5'd11);
        at_neg();
        cmp("nfs.zero.lwstall", 32'(lwstall), 32'd0);
        step();
        set_lw(5'd8);
        step();
        set_add(5'd9, 5'd10, 5'd11);
        at_neg();
        cmp("nfs.other.lwstall", 32'(lwstall), 32'd0);
        step();

        // Flush a valid sw.
        set_instr(1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 5'd0);
        flush_e = 1'b1;
        step();
        flush_e = 1'b0;
        set_add(5'd1, 5'd2, 5'd3);
        cmp("fl.memwrite_e", 32'(memwrite_e), 32'd0);
        cmp("fl.valid_e", 32'(valid_e), 32'd0);
        step();

        // Flush together with a load-use stall.
        set_lw(5'd8);
        step();
        set_add(5'd8, 5'd12, 5'd13);
        flush_e = 1'b1;
        at_neg();
        cmp("fs.lwstall", 32'(lwstall), 32'd1);
        step();
        flush_e = 1'b0;
        cmp("fs.valid_e", 32'(valid_e), 32'd0);
        cmp("fs.count", 32'(stall_count), 32'd2);
        step();

        // Clear coinciding with a stall.
        set_lw(5'd8);
        step();
        set_add(5'd12, 5'd8, 5'd13);
        clr_count = 1'b1;
        at_neg();
        cmp("clr.lwstall", 32'(lwstall), 32'd1);
        step();
        clr_count = 1'b0;
        cmp("clr.count", 32'(stall_count), 32'd0);
        step();

        // Saturation: 20 load-use pairs on a 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            set_lw(5'd8);
            step();
            set_add(5'd8, 5'd9, 5'd10);
            step();
            step();
        end
        cmp("sat.count", 32'(stall_count), 32'd15);

        // Reset mid-stall discards the stall; first edge after release loads normally.
        set_lw(5'd8);
        step();
        set_add(5'd8, 5'd9, 5'd10);
        at_neg();
        cmp("rms.lwstall", 32'(lwstall), 32'd1);
        reset_n = 1'b0;
        #1;
        cmp("rms.count", 32'(stall_count), 32'd0);
        cmp("rms.lwstall_rst", 32'(lwstall), 32'd0);
        at_neg();
        reset_n = 1'b1;
        step();
        cmp("rms.valid_e", 32'(valid_e), 32'd1);
        cmp("rms.rs_e", 32'(rs_e), 32'd8);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
